// File: rtl/rx_pkg.sv
// Shared encodings for the Rx symbol packer: modulation mode, FSM states
// and the bits-per-symbol helper.
package rx_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    PACK = 1'b1
  } state_t;

  localparam logic MODE_BPSK = 1'b1;
  localparam logic MODE_QPSK = 1'b0;

  function automatic logic [1:0] bits_per_symbol(input logic mode);
    return (mode == MODE_QPSK) ? 2'd2 : 2'd1;
  endfunction

endpackage

// File: rtl/packer_fifo.sv
// Synchronous word FIFO with first-word-fall-through output; the head entry
// is visible on dout whenever the FIFO is not empty.
module packer_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic             dropped
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  // A pop frees the head slot in the same cycle, so a push into a full FIFO
  // still lands when the consumer is draining.
  always_comb begin
    full    = (count == CW'(DEPTH));
    empty   = (count == '0);
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    dropped = push && !do_push;
    dout    = empty ? '0 : mem[rd_ptr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/rx_symbol_packer.sv
// Packs BPSK/QPSK symbol decisions into framed words and presents them on an
// AXI-Stream master through a small buffering FIFO.
module rx_symbol_packer
  import rx_pkg::*;
#(
  parameter int BYTES      = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                 clk_32M768,
  input  logic                 rst_n_32M768,
  input  logic                 clk_enable,
  input  logic                 is_bpsk,
  input  logic                 frame_start,
  input  logic [LEN_WIDTH-1:0] frame_len,
  input  logic [1:0]           sym_data,
  input  logic                 sym_valid,
  output logic [8*BYTES-1:0]   m_tdata,
  output logic                 m_tvalid,
  input  logic                 m_tready,
  output logic                 m_tlast,
  output logic                 m_tuser,
  output logic                 busy,
  output logic                 overflow
);

  localparam int W     = 8 * BYTES;
  localparam int CNT_W = $clog2(W + 1);

  state_t               state;
  logic [W-1:0]         shift_reg;
  logic [W-1:0]         shift_next;
  logic [CNT_W-1:0]     bit_cnt;
  logic [CNT_W-1:0]     bit_cnt_next;
  logic [LEN_WIDTH-1:0] word_cnt;
  logic [LEN_WIDTH-1:0] len;
  logic                 mode;
  logic [1:0]           bps;
  logic                 word_done;
  logic                 last_word;
  logic                 push;
  logic                 pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 dropped;
  logic [W+1:0]         fifo_din;
  logic [W+1:0]         fifo_dout;

  // The earliest received bit ends up in the MSB because every symbol
  // shifts in from the LSB side.
  always_comb begin
    bps          = bits_per_symbol(mode);
    shift_next   = (mode == MODE_BPSK) ? {shift_reg[W-2:0], sym_data[0]}
                                       : {shift_reg[W-3:0], sym_data};
    bit_cnt_next = bit_cnt + CNT_W'(bps);
    word_done    = (bit_cnt_next == CNT_W'(W));
    last_word    = (word_cnt == len - LEN_WIDTH'(1));
    push         = (state == PACK) && clk_enable && sym_valid && word_done;
    fifo_din     = {mode, last_word, shift_next};
    pop          = m_tvalid && m_tready;
  end

  // Dropped words still advance word_cnt so tlast stays on the true last word.
  always_ff @(posedge clk_32M768 or negedge rst_n_32M768) begin
    if (!rst_n_32M768) begin
      state     <= IDLE;
      busy      <= 1'b0;
      shift_reg <= '0;
      bit_cnt   <= '0;
      word_cnt  <= '0;
      len       <= '0;
      mode      <= MODE_QPSK;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (clk_enable && frame_start && (frame_len != '0)) begin
            state     <= PACK;
            busy      <= 1'b1;
            len       <= frame_len;
            mode      <= is_bpsk;
            overflow  <= 1'b0;
            shift_reg <= '0;
            bit_cnt   <= '0;
            word_cnt  <= '0;
          end
        end
        PACK: begin
          if (clk_enable && sym_valid) begin
            shift_reg <= shift_next;
            if (word_done) begin
              bit_cnt  <= '0;
              word_cnt <= word_cnt + LEN_WIDTH'(1);
              if (dropped) begin
                overflow <= 1'b1;
              end
              if (last_word) begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              bit_cnt <= bit_cnt_next;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  packer_fifo #(
    .WIDTH (W + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk_32M768),
    .rst_n   (rst_n_32M768),
    .push    (push),
    .pop     (pop),
    .din     (fifo_din),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .dropped (dropped)
  );

  assign m_tvalid = !fifo_empty;
  assign m_tdata  = fifo_dout[W-1:0];
  assign m_tlast  = fifo_dout[W];
  assign m_tuser  = fifo_dout[W+1];

endmodule

// File: tb/tb_rx_symbol_packer.sv
// Randomised bench for rx_symbol_packer (BYTES=1, FIFO_DEPTH=4); expected words
// come from a bit-list model of the framing rules.
module tb_rx_symbol_packer;

  logic       clk_32M768 = 1'b0;
  logic       rst_n_32M768;
  logic       clk_enable;
  logic       is_bpsk;
  logic       frame_start;
  logic [7:0] frame_len;
  logic [1:0] sym_data;
  logic       sym_valid;
  logic [7:0] m_tdata;
  logic       m_tvalid;
  logic       m_tready = 1'b0;
  logic       m_tlast;
  logic       m_tuser;
  logic       busy;
  logic       overflow;

  int checks   = 0;
  int failures = 0;

  logic [9:0] got_q[$];
  logic [9:0] exp_q[$];
  logic [1:0] sym_q[$];
  logic       rdy_random = 1'b0;
  logic       rdy_value  = 1'b1;

  rx_symbol_packer #(
    .BYTES      (1),
    .FIFO_DEPTH (4),
    .LEN_WIDTH  (8)
  ) dut (
    .clk_32M768   (clk_32M768),
    .rst_n_32M768 (rst_n_32M768),
    .clk_enable   (clk_enable),
    .is_bpsk      (is_bpsk),
    .frame_start  (frame_start),
    .frame_len    (frame_len),
    .sym_data     (sym_data),
    .sym_valid    (sym_valid),
    .m_tdata      (m_tdata),
    .m_tvalid     (m_tvalid),
    .m_tready     (m_tready),
    .m_tlast      (m_tlast),
    .m_tuser      (m_tuser),
    .busy         (busy),
    .overflow     (overflow)
  );

  always #5 clk_32M768 = ~clk_32M768;

  always @(posedge clk_32M768) begin
    #1;
    m_tready = rdy_random ? 1'($urandom) : rdy_value;
  end

  // Handshake values are stable at the falling edge and belong to the next rising edge.
  always @(negedge clk_32M768) begin
    if (rst_n_32M768 && m_tvalid && m_tready) begin
      got_q.push_back({m_tuser, m_tlast, m_tdata});
    end
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected test completion");
    $fatal(1, "[TB] watchdog");
  end

  // Expected output: concatenate payload bits in arrival order, cut into bytes.
  function automatic void build_expected(input logic mode, input int len, input int cap);
    bit bits[$];
    exp_q.delete();
    foreach (sym_q[i]) begin
      if (mode) begin
        bits.push_back(sym_q[i][0]);
      end else begin
        bits.push_back(sym_q[i][1]);
        bits.push_back(sym_q[i][0]);
      end
    end
    for (int w = 0; w < len; w++) begin
      int v = 0;
      for (int b = 0; b < 8; b++) begin
        v = v * 2 + int'(bits[8 * w + b]);
      end
      if (w < cap) begin
        exp_q.push_back({mode, logic'(w == len - 1), 8'(v)});
      end
    end
  endfunction

  function automatic void fill_random(input logic mode, input int len);
    sym_q.delete();
    for (int i = 0; i < len * (mode ? 8 : 4); i++) begin
      sym_q.push_back(2'($urandom_range(0, 3)));
    end
  endfunction

  task automatic strobe(input logic fs, input logic [7:0] fl, input logic [1:0] sd,
                        input logic sv, input logic bp, input int gap_max);
    int gaps;
    frame_start = fs;
    frame_len   = fl;
    sym_data    = sd;
    sym_valid   = sv;
    is_bpsk     = bp;
    clk_enable  = 1'b1;
    @(posedge clk_32M768); #1;
    clk_enable = 1'b0;
    gaps = $urandom_range(0, gap_max);
    for (int g = 0; g < gaps; g++) begin
      frame_start = 1'($urandom);
      sym_valid   = 1'($urandom);
      sym_data    = 2'($urandom);
      is_bpsk     = 1'($urandom);
      @(posedge clk_32M768); #1;
    end
    frame_start = 1'b0;
    sym_valid   = 1'b0;
  endtask

  task automatic send_frame(input logic mode, input int len, input bit toggle);
    strobe(1'b1, 8'(len), 2'($urandom), 1'($urandom), mode, 2);
    foreach (sym_q[i]) begin
      if ($urandom_range(0, 3) == 0) begin
        strobe(1'($urandom), 8'($urandom), 2'($urandom), 1'b0, toggle ? 1'($urandom) : mode, 2);
      end
      strobe(1'($urandom_range(0, 7) == 0), 8'($urandom), sym_q[i], 1'b1,
             toggle ? 1'($urandom) : mode, 2);
    end
  endtask

  task automatic wait_words(input int n, input int budget);
    for (int c = 0; c < budget && got_q.size() < n; c++) begin
      @(posedge clk_32M768); #1;
    end
    repeat (6) begin
      @(posedge clk_32M768); #1;
    end
  endtask

  task automatic test_reset;
    rst_n_32M768 = 1'b0;
    clk_enable = 1'b0; is_bpsk = 1'b0; frame_start = 1'b0;
    frame_len = '0; sym_data = '0; sym_valid = 1'b0;
    repeat (3) @(posedge clk_32M768);
    #1;
    checks += 6;
    if (m_tdata !== 8'h00) begin failures++; $display("[TB] FAIL reset_tdata: got %h, expected 00", m_tdata); end
    if (m_tvalid !== 1'b0) begin failures++; $display("[TB] FAIL reset_tvalid: got %b, expected 0", m_tvalid); end
    if (m_tlast !== 1'b0) begin failures++; $display("[TB] FAIL reset_tlast: got %b, expected 0", m_tlast); end
    if (m_tuser !== 1'b0) begin failures++; $display("[TB] FAIL reset_tuser: got %b, expected 0", m_tuser); end
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b, expected 0", busy); end
    if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL reset_overflow: got %b, expected 0", overflow); end
    rst_n_32M768 = 1'b1;
    @(posedge clk_32M768); #1;
  endtask

  task automatic test_latency;
    rdy_random = 1'b0; rdy_value = 1'b1;
    fill_random(1'b1, 1);
    build_expected(1'b1, 1, 1);
    got_q.delete();
    strobe(1'b1, 8'd1, 2'b00, 1'b1, 1'b1, 0);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("[TB] FAIL latency_busy_start: got %b, expected 1", busy); end
    for (int i = 0; i < 7; i++) strobe(1'b0, 8'd0, sym_q[i], 1'b1, 1'b0, 0);
    checks++;
    if (m_tvalid !== 1'b0) begin failures++; $display("[TB] FAIL latency_early_valid: got %b, expected 0", m_tvalid); end
    strobe(1'b0, 8'd0, sym_q[7], 1'b1, 1'b0, 0);
    checks += 4;
    if (m_tvalid !== 1'b1) begin failures++; $display("[TB] FAIL latency_valid: got %b, expected 1", m_tvalid); end
    if ({m_tuser, m_tlast, m_tdata} !== exp_q[0]) begin
      failures++; $display("[TB] FAIL latency_word: got %h, expected %h", {m_tuser, m_tlast, m_tdata}, exp_q[0]);
    end
    if (m_tlast !== 1'b1) begin failures++; $display("[TB] FAIL latency_tlast: got %b, expected 1", m_tlast); end
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL latency_busy_end: got %b, expected 0", busy); end
    wait_words(1, 20);
  endtask

  task automatic test_bpsk;
    logic [1:0] fixed[16] = '{1,0,1,0,0,1,0,1, 1,1,1,1,1,1,1,1};
    for (int f = 0; f < 4; f++) begin
      int len;
      if (f == 0) begin
        len = 2; rdy_random = 1'b0; rdy_value = 1'b1;
        sym_q.delete();
        foreach (fixed[i]) sym_q.push_back(fixed[i]);
      end else begin
        len = $urandom_range(1, 4); rdy_random = 1'b1;
        fill_random(1'b1, len);
      end
      build_expected(1'b1, len, len);
      got_q.delete();
      send_frame(1'b1, len, 1'b0);
      wait_words(exp_q.size(), 400);
      checks++;
      if (got_q.size() != exp_q.size()) begin
        failures++; $display("[TB] FAIL bpsk_count[%0d]: got %0d words, expected %0d", f, got_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) begin
        logic [9:0] g;
        g = (i < got_q.size()) ? got_q[i] : 'x;
        checks++;
        if (g !== exp_q[i]) begin
          failures++; $display("[TB] FAIL bpsk_word[%0d][%0d]: got %h, expected %h", f, i, g, exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_qpsk;
    logic [1:0] fixed[8] = '{3,0,2,1,1,1,1,1};
    for (int f = 0; f < 4; f++) begin
      int len;
      if (f == 0) begin
        len = 2; rdy_random = 1'b0; rdy_value = 1'b1;
        sym_q.delete();
        foreach (fixed[i]) sym_q.push_back(fixed[i]);
      end else begin
        len = $urandom_range(1, 5); rdy_random = 1'b1;
        fill_random(1'b0, len);
      end
      build_expected(1'b0, len, len);
      got_q.delete();
      send_frame(1'b0, len, 1'b0);
      wait_words(exp_q.size(), 400);
      checks++;
      if (got_q.size() != exp_q.size()) begin
        failures++; $display("[TB] FAIL qpsk_count[%0d]: got %0d words, expected %0d", f, got_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) begin
        logic [9:0] g;
        g = (i < got_q.size()) ? got_q[i] : 'x;
        checks++;
        if (g !== exp_q[i]) begin
          failures++; $display("[TB] FAIL qpsk_word[%0d][%0d]: got %h, expected %h", f, i, g, exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_mode_toggle;
    rdy_random = 1'b1;
    fill_random(1'b0, 3);
    build_expected(1'b0, 3, 3);
    got_q.delete();
    send_frame(1'b0, 3, 1'b1);
    wait_words(exp_q.size(), 400);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++; $display("[TB] FAIL toggle_count: got %0d words, expected %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      logic [9:0] g;
      g = (i < got_q.size()) ? got_q[i] : 'x;
      checks++;
      if (g !== exp_q[i]) begin
        failures++; $display("[TB] FAIL toggle_word[%0d]: got %h, expected %h", i, g, exp_q[i]);
      end
    end
  endtask

  task automatic test_overflow;
    rdy_random = 1'b0; rdy_value = 1'b0;
    @(posedge clk_32M768); #1;
    fill_random(1'b1, 6);
    build_expected(1'b1, 6, 4);
    got_q.delete();
    send_frame(1'b1, 6, 1'b0);
    checks += 3;
    if (overflow !== 1'b1) begin failures++; $display("[TB] FAIL ovf_flag: got %b, expected 1", overflow); end
    if (m_tvalid !== 1'b1) begin failures++; $display("[TB] FAIL ovf_valid_held: got %b, expected 1", m_tvalid); end
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL ovf_busy: got %b, expected 0", busy); end
    rdy_value = 1'b1;
    wait_words(exp_q.size(), 100);
    checks += 2;
    if (got_q.size() != exp_q.size()) begin
      failures++; $display("[TB] FAIL ovf_count: got %0d words, expected %0d", got_q.size(), exp_q.size());
    end
    if (overflow !== 1'b1) begin failures++; $display("[TB] FAIL ovf_sticky: got %b, expected 1", overflow); end
    foreach (exp_q[i]) begin
      logic [9:0] g;
      g = (i < got_q.size()) ? got_q[i] : 'x;
      checks++;
      if (g !== exp_q[i]) begin
        failures++; $display("[TB] FAIL ovf_word[%0d]: got %h, expected %h", i, g, exp_q[i]);
      end
    end
  endtask

  task automatic test_zero_len;
    rdy_random = 1'b0; rdy_value = 1'b1;
    got_q.delete();
    strobe(1'b1, 8'd0, 2'($urandom), 1'b1, 1'b1, 0);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL zero_len_busy: got %b, expected 0", busy); end
    repeat (6) begin @(posedge clk_32M768); #1; end
    checks += 3;
    if (m_tvalid !== 1'b0) begin failures++; $display("[TB] FAIL zero_len_valid: got %b, expected 0", m_tvalid); end
    if (got_q.size() != 0) begin failures++; $display("[TB] FAIL zero_len_words: got %0d words, expected 0", got_q.size()); end
    if (overflow !== 1'b1) begin failures++; $display("[TB] FAIL zero_len_ovf_kept: got %b, expected 1", overflow); end
    fill_random(1'b1, 1);
    build_expected(1'b1, 1, 1);
    strobe(1'b1, 8'd1, 2'($urandom), 1'b1, 1'b1, 0);
    checks += 2;
    if (busy !== 1'b1) begin failures++; $display("[TB] FAIL restart_busy: got %b, expected 1", busy); end
    if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL restart_ovf_clear: got %b, expected 0", overflow); end
    foreach (sym_q[i]) strobe(1'b0, 8'd0, sym_q[i], 1'b1, 1'($urandom), 1);
    wait_words(1, 50);
    checks += 2;
    if (got_q.size() != 1) begin failures++; $display("[TB] FAIL restart_count: got %0d words, expected 1", got_q.size()); end
    if (got_q.size() > 0 && got_q[0] !== exp_q[0]) begin
      failures++; $display("[TB] FAIL restart_word: got %h, expected %h", got_q[0], exp_q[0]);
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [1:0] fixed[8] = '{0,0,1,1,1,1,0,0};
    rdy_random = 1'b0; rdy_value = 1'b1;
    got_q.delete();
    strobe(1'b1, 8'd2, 2'b00, 1'b0, 1'b1, 0);
    for (int i = 0; i < 3; i++) strobe(1'b0, 8'd0, 2'($urandom), 1'b1, 1'b1, 0);
    rst_n_32M768 = 1'b0;
    #1;
    checks += 3;
    if (m_tvalid !== 1'b0) begin failures++; $display("[TB] FAIL midrst_valid: got %b, expected 0", m_tvalid); end
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL midrst_busy: got %b, expected 0", busy); end
    if (m_tdata !== 8'h00) begin failures++; $display("[TB] FAIL midrst_tdata: got %h, expected 00", m_tdata); end
    strobe(1'b1, 8'd1, 2'b11, 1'b1, 1'b1, 0);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL midrst_held_busy: got %b, expected 0", busy); end
    rst_n_32M768 = 1'b1;
    @(posedge clk_32M768); #1;
    sym_q.delete();
    foreach (fixed[i]) sym_q.push_back(fixed[i]);
    build_expected(1'b1, 1, 1);
    send_frame(1'b1, 1, 1'b0);
    wait_words(1, 100);
    checks += 2;
    if (got_q.size() != 1) begin failures++; $display("[TB] FAIL midrst_count: got %0d words, expected 1", got_q.size()); end
    if (got_q.size() > 0 && got_q[0] !== exp_q[0]) begin
      failures++; $display("[TB] FAIL midrst_word: got %h, expected %h", got_q[0], exp_q[0]);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_bpsk();
    test_qpsk();
    test_mode_toggle();
    test_overflow();
    test_zero_len();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
